conv_window_stream: RTL

Streaming sliding-window generator for the CNN convolution datapath. It accepts an image one pixel per handshake in raster order, with all D channels of a pixel carried together. It keeps S-1 line buffers plus an S×S window register and emits one S×S×D window per valid filter position. The window honours a programmable stride, with valid/ready backpressure on both sides. It replaces full-frame combinational patch extraction, so the conv units can be fed at one window per cycle from a pixel stream instead of holding the whole image in flip-flops.

---
 rtl/conv_window_stream.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_window_stream.sv
// Streaming S x S x D sliding-window generator: S-1 line buffers feed a shifting
// window register, emitting one window per stride-aligned position with valid/ready flow.
module conv_window_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int S          = 5,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int STRIDE     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D*DATA_WIDTH-1:0]      in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [D*S*S*DATA_WIDTH-1:0]  out_data,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int PW       = D * DATA_WIDTH;
  localparam int CW       = $clog2(W);
  localparam int RW       = $clog2(H);
  localparam int PHW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LAST_ROW = (S - 1) + ((H - S) / STRIDE) * STRIDE;
  localparam int LAST_COL = (S - 1) + ((W - S) / STRIDE) * STRIDE;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [PHW-1:0] colph;
  logic [PHW-1:0] rowph;
  logic           accept;
  logic           emit;
  logic           col_wrap;
  logic           row_wrap;

  logic [PW-1:0] lb  [S-1][W];
  logic [PW-1:0] win [S][S];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col == CW'(W - 1));
  assign row_wrap = (row == RW'(H - 1));
  assign emit     = (row >= RW'(S - 1)) && (col >= CW'(S - 1)) &&
                    (rowph == '0) && (colph == '0);

  // Phases are zero exactly at index S-1 and then cycle through the stride,
  // so a zero phase marks every stride-aligned bottom-right position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      colph <= '0;
      rowph <= '0;
    end else if (accept) begin
      col <= col_wrap ? '0 : col + 1'b1;
      if (col_wrap || col < CW'(S - 1))
        colph <= '0;
      else
        colph <= (colph == PHW'(STRIDE - 1)) ? '0 : colph + 1'b1;
      if (col_wrap) begin
        row <= row_wrap ? '0 : row + 1'b1;
        if (row_wrap || row < RW'(S - 1))
          rowph <= '0;
        else
          rowph <= (rowph == PHW'(STRIDE - 1)) ? '0 : rowph + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_wrap && row_wrap;
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_last  <= (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Line buffer row 0 is the oldest; the window's new right column reads the
  // buffers before they shift, so it holds rows r-S+1 .. r-1 plus the live pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < S - 2; r++)
        lb[r][col] <= lb[r+1][col];
      lb[S-2][col] <= in_data;
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S - 1; j++)
          win[i][j] <= win[i][j+1];
      for (int i = 0; i < S - 1; i++)
        win[i][S-1] <= lb[i][col];
      win[S-1][S-1] <= in_data;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < D; k++)
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++)
          out_data[((k*S+i)*S+j)*DATA_WIDTH +: DATA_WIDTH] = win[i][j][k*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule
